// File: rtl/alu_mc_pkg.sv
// Shared constants for the multi-cycle ALU: widths, opcodes, FSM states and flag bundle.
package alu_mc_pkg;
  localparam int ALU_DSIZE = 16;
  localparam int ALU_OPW   = 4;

  localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_XOR  = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_COM  = 4'd4;
  localparam logic [ALU_OPW-1:0] ALU_MUL  = 4'd5;
  localparam logic [ALU_OPW-1:0] ALU_ADDI = 4'd6;
  localparam logic [ALU_OPW-1:0] ALU_LW   = 4'd7;
  localparam logic [ALU_OPW-1:0] ALU_SW   = 4'd8;
  localparam logic [ALU_OPW-1:0] ALU_BEQ  = 4'd9;
  localparam logic [ALU_OPW-1:0] ALU_OR   = 4'd10;
  localparam logic [ALU_OPW-1:0] ALU_SLL  = 4'd11;
  localparam logic [ALU_OPW-1:0] ALU_SRL  = 4'd12;
  localparam logic [ALU_OPW-1:0] ALU_SRA  = 4'd13;
  localparam logic [ALU_OPW-1:0] ALU_SLT  = 4'd14;
  localparam logic [ALU_OPW-1:0] ALU_NOP  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;
endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between register-read and writeback stages.
interface alu_mc_if #(
  parameter int DSIZE = 16,
  parameter int OPW   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] a;
  logic [DSIZE-1:0] b;
  logic [OPW-1:0]   op;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] out;
  logic [DSIZE-1:0] out_hi;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, out_hi, zero, neg, carry, ovf
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, out_hi, zero, neg, carry, ovf
  );
endinterface

// File: rtl/alu_mc_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, DSIZE cycles.
module mul_seq #(
  parameter int DSIZE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [DSIZE-1:0]   a_i,
  input  logic [DSIZE-1:0]   b_i,
  output logic               done_o,
  output logic [2*DSIZE-1:0] prod_o
);
  localparam int CW = $clog2(DSIZE);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*DSIZE-1:0] acc_q, acc_d;
  logic [2*DSIZE-1:0] mcand_q;
  logic [DSIZE-1:0]   mplr_q;

  assign acc_d = acc_q + (mplr_q[0] ? mcand_q : '0);
  // Product is taken combinationally from the last step so the caller can load it on that same edge.
  assign done_o = busy_q && (cnt_q == CW'(DSIZE-1));
  assign prod_o = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= {{DSIZE{1'b0}}, a_i};
      mplr_q  <= b_i;
    end else if (busy_q) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result/flags, valid/ready on both sides and a sequential multiplier.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DSIZE = ALU_DSIZE,
  parameter int OPW   = ALU_OPW
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(DSIZE);

  alu_state_e       state_q, state_d;
  logic [DSIZE-1:0] out_q, hi_q;
  alu_flags_t       flags_q;

  logic [DSIZE-1:0] a, b, res;
  logic [OPW-1:0]   op;
  logic [DSIZE:0]   sum, dif;
  logic [SHW-1:0]   shamt;
  alu_flags_t       fl;
  logic             in_ready, accept, mul_start, load_alu, load_mul, mul_done;
  logic [2*DSIZE-1:0] prod;

  assign a     = bus.a;
  assign b     = bus.b;
  assign op    = bus.op;
  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  // Single-cycle result path; MUL is handled by the sequencer and yields zero here.
  always_comb begin
    res      = '0;
    fl       = '0;
    case (op)
      ALU_ADD, ALU_ADDI: begin
        res      = sum[DSIZE-1:0];
        fl.carry = sum[DSIZE];
        fl.ovf   = (a[DSIZE-1] == b[DSIZE-1]) && (sum[DSIZE-1] != a[DSIZE-1]);
      end
      ALU_LW, ALU_SW: begin
        res      = sum[DSIZE-1:0];
        fl.carry = sum[DSIZE];
      end
      ALU_SUB: begin
        res      = dif[DSIZE-1:0];
        fl.carry = dif[DSIZE];
        fl.ovf   = (a[DSIZE-1] != b[DSIZE-1]) && (dif[DSIZE-1] != a[DSIZE-1]);
      end
      ALU_AND: res = a & b;
      ALU_XOR: res = a ^ b;
      ALU_OR:  res = a | b;
      ALU_COM: res = {{(DSIZE-1){1'b0}}, (a <= b)};
      ALU_SLT: res = {{(DSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: res = a << shamt;
      ALU_SRL: res = a >> shamt;
      ALU_SRA: res = $signed(a) >>> shamt;
      default: res = '0;
    endcase
    if (op == ALU_BEQ)      fl.zero = (a == b);
    else if (op == ALU_NOP) fl.zero = 1'b0;
    else                    fl.zero = (res == '0);
    fl.neg = res[DSIZE-1];
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
    accept    = bus.in_valid && in_ready;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (op == ALU_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else begin
            state_d  = ST_HOLD;
            load_alu = 1'b1;
          end
        end else if (state_q == ST_HOLD && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d  = ST_HOLD;
          load_mul = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else if (load_alu) begin
      out_q   <= res;
      hi_q    <= '0;
      flags_q <= fl;
    end else if (load_mul) begin
      out_q   <= prod[DSIZE-1:0];
      hi_q    <= prod[2*DSIZE-1:DSIZE];
      flags_q <= '{zero: (prod == '0), neg: prod[DSIZE-1], carry: 1'b0, ovf: 1'b0};
    end
  end

  mul_seq #(.DSIZE(DSIZE)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (prod)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out       = out_q;
  assign bus.out_hi    = hi_q;
  assign bus.zero      = flags_q.zero;
  assign bus.neg       = flags_q.neg;
  assign bus.carry     = flags_q.carry;
  assign bus.ovf       = flags_q.ovf;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table, handshake corner sequences, randomized ops vs. model.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mc_if #(.DSIZE(16), .OPW(4)) bus ();

  alu_mc #(.DSIZE(16), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] out;
    logic [15:0] hi;
    logic [3:0]  fl;   // {zero, neg, carry, ovf}
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [15:0] hi;
    logic [3:0]  fl;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference behaviour from the opcode table using plain integer arithmetic.
  function automatic res_t model(input int op, input int a, input int b);
    res_t   r;
    longint p;
    int     sa, sb, s, sh;
    r  = '{out: 16'h0, hi: 16'h0, fl: 4'h0};
    p  = 0;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    sh = b % 16;
    s  = 0;
    case (op)
      0, 6: begin
        s = a + b; r.out = s[15:0]; r.fl[1] = (s > 65535);
        r.fl[0] = (sa + sb > 32767) || (sa + sb < -32768);
      end
      7, 8: begin s = a + b; r.out = s[15:0]; r.fl[1] = (s > 65535); end
      1: begin
        s = a - b; r.out = s[15:0]; r.fl[1] = (a < b);
        r.fl[0] = (sa - sb > 32767) || (sa - sb < -32768);
      end
      2:  begin s = a & b; r.out = s[15:0]; end
      3:  begin s = a ^ b; r.out = s[15:0]; end
      10: begin s = a | b; r.out = s[15:0]; end
      4:  r.out = (a <= b) ? 16'd1 : 16'd0;
      14: r.out = (sa < sb) ? 16'd1 : 16'd0;
      5:  begin p = longint'(a) * longint'(b); r.out = p[15:0]; r.hi = p[31:16]; end
      11: begin s = a << sh; r.out = s[15:0]; end
      12: begin s = a >> sh; r.out = s[15:0]; end
      13: begin s = sa >>> sh; r.out = s[15:0]; end
      default: r.out = 16'h0;
    endcase
    if (op == 9)       r.fl[3] = (a == b);
    else if (op == 15) r.fl[3] = 1'b0;
    else if (op == 5)  r.fl[3] = (p == 0);
    else               r.fl[3] = (r.out == 16'h0);
    r.fl[2] = r.out[15];
    return r;
  endfunction

  // Issue one op with out_ready held high; report the outputs at the first valid cycle and latency.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output res_t r, output int lat);
    int w;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 40);
    r.out = bus.out; r.hi = bus.out_hi;
    r.fl  = {bus.zero, bus.neg, bus.carry, bus.ovf};
  endtask

  vec_t vecs[18];

  initial begin
    res_t r, e;
    int   lat, cnt;
    logic [3:0] rop;
    logic [15:0] ra, rb;

    vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0101};
    vecs[1]  = '{4'd1,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0110};
    vecs[2]  = '{4'd9,  16'h1234, 16'h1234, 16'h0000, 16'h0000, 4'b1000};
    vecs[3]  = '{4'd9,  16'h0001, 16'h0002, 16'h0000, 16'h0000, 4'b0000};
    vecs[4]  = '{4'd5,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0000};
    vecs[5]  = '{4'd13, 16'h8000, 16'h0013, 16'hF000, 16'h0000, 4'b0100};
    vecs[6]  = '{4'd14, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 4'b0000};
    vecs[7]  = '{4'd4,  16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'b1000};
    vecs[8]  = '{4'd15, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b0000};
    vecs[9]  = '{4'd10, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 4'b0100};
    vecs[10] = '{4'd11, 16'h0001, 16'h0104, 16'h0010, 16'h0000, 4'b0000};
    vecs[11] = '{4'd12, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 4'b0000};
    vecs[12] = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1010};
    vecs[13] = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001};
    vecs[14] = '{4'd7,  16'hFFFF, 16'h0002, 16'h0001, 16'h0000, 4'b0010};
    vecs[15] = '{4'd5,  16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b1000};
    vecs[16] = '{4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'b0000};
    vecs[17] = '{4'd3,  16'hF0F0, 16'h0FF0, 16'hFF00, 16'h0000, 4'b0100};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.op = '0;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_out_hi", 32'(bus.out_hi), 32'd0);
    chk("rst_flags", 32'({bus.zero, bus.neg, bus.carry, bus.ovf}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      chk($sformatf("vec%0d_out", i), 32'(r.out), 32'(vecs[i].out));
      chk($sformatf("vec%0d_hi", i), 32'(r.hi), 32'(vecs[i].hi));
      chk($sformatf("vec%0d_flags", i), 32'(r.fl), 32'(vecs[i].fl));
      chk($sformatf("vec%0d_lat", i), 32'(lat), (vecs[i].op == 4'd5) ? 32'd17 : 32'd1);
    end

    // MUL busy window with a pending ADD that must wait for the product to be consumed.
    @(negedge clk);
    bus.op = 4'd5; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.op = 4'd0; bus.a = 16'h0002; bus.b = 16'h0003;
    cnt = 0; lat = 0;
    do begin
      @(negedge clk); lat++;
      if (!bus.in_ready && !bus.out_valid) cnt++;
    end while (!bus.out_valid && lat < 40);
    chk("mul_busy_cycles", 32'(cnt), 32'd16);
    chk("mul_lat", 32'(lat), 32'd17);
    chk("mul_lo", 32'(bus.out), 32'h0001);
    chk("mul_hi", 32'(bus.out_hi), 32'hFFFE);
    @(negedge clk); @(negedge clk);
    chk("mul_held_out", 32'(bus.out), 32'h0001);
    chk("mul_held_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pend_add_out", 32'(bus.out), 32'd5);
    chk("pend_add_hi", 32'(bus.out_hi), 32'd0);
    chk("pend_add_valid", 32'(bus.out_valid), 32'd1);

    // Backpressure on an ADD result, then a back-to-back XOR on release.
    @(negedge clk);
    bus.op = 4'd0; bus.a = 16'h7FFF; bus.b = 16'h0001; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.out_valid && !bus.in_ready && bus.out == 16'h8000 &&
          {bus.zero, bus.neg, bus.carry, bus.ovf} == 4'b0101) cnt++;
    end
    chk("bp_stable_cycles", 32'(cnt), 32'd5);
    bus.out_ready = 1'b1;
    bus.op = 4'd3; bus.a = 16'hF0F0; bus.b = 16'h0FF0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_xor_out", 32'(bus.out), 32'hFF00);
    chk("b2b_xor_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("b2b_idle_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    bus.op = 4'd5; bus.a = 16'h0003; bus.b = 16'h0004; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out", 32'(bus.out), 32'd0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("mrst_no_result", 32'(cnt), 32'd0);
    run_op(4'd0, 16'h0002, 16'h0003, r, lat);
    chk("post_rst_add_out", 32'(r.out), 32'd5);
    chk("post_rst_add_lat", 32'(lat), 32'd1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       ra = 16'h8000;
        1:       ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
      e = model(int'(rop), int'(ra), int'(rb));
      run_op(rop, ra, rb, r, lat);
      chk($sformatf("rnd%0d_op%0d_out", i, rop), 32'(r.out), 32'(e.out));
      chk($sformatf("rnd%0d_op%0d_hi", i, rop), 32'(r.hi), 32'(e.hi));
      chk($sformatf("rnd%0d_op%0d_flags", i, rop), 32'(r.fl), 32'(e.fl));
      chk($sformatf("rnd%0d_op%0d_lat", i, rop), 32'(lat), (rop == 4'd5) ? 32'd17 : 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Registered result with valid/ready handshake on both sides.
- Single-cycle ops complete in 1 cycle; MUL uses an iterative shift-add unit taking DSIZE cycles and returns the full 2*DSIZE product.
- Adds flags (zero, neg, carry, ovf), plus OR, shift and signed-compare ops.
- Sits between the decode/register-read stage and writeback/memory-address logic.

Parameters:
- DSIZE, 16, operand/result width in bits (>=4, power of two).
- OPW, 4, opcode width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept this cycle.
- a  in  DSIZE  operand 1.
- b  in  DSIZE  operand 2 (immediate already extended for ADDI/LW/SW).
- op  in  OPW  operation code.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes result.
- out  out  DSIZE  result (low half for MUL).
- out_hi  out  DSIZE  high half of MUL product; 0 for other ops.
- zero  out  1  see flag rules.
- neg  out  1  out[DSIZE-1].
- carry  out  1  carry-out of ADD/ADDI/LW/SW; borrow (a<b unsigned) for SUB; else 0.
- ovf  out  1  signed overflow for ADD/ADDI/SUB; else 0.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - out, out_hi = 0; zero, neg, carry, ovf = 0; out_valid = 0; multiplier state cleared.
  - Reset mid-multiply aborts it; no result is produced.
- Opcodes:
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 XOR.
  - 4 COM: unsigned a<=b → 1 else 0.
  - 5 MUL.
  - 6 ADDI, 7 LW, 8 SW: a+b.
  - 9 BEQ: out=0, zero=(a==b).
  - 10 OR.
  - 11 SLL, 12 SRL, 13 SRA: shift a by b[$clog2(DSIZE)-1:0]; upper bits of b ignored.
  - 14 SLT: signed a<b → 1 else 0.
  - 15: out=0, all flags 0.
- Width: all arithmetic modulo 2^DSIZE; COM/SLT results zero-extended.
- zero = (out==0) for every op except BEQ (equality) and op 15 (0).
- FSM states: IDLE, MUL, HOLD.
  - in_ready = (state==IDLE) | (state==HOLD & out_ready).
  - Accept occurs when in_valid & in_ready.
  - Accept of a non-MUL op: result and flags registered at that edge; state→HOLD; out_valid=1 the next cycle (latency 1).
  - Accept of MUL: operands latched, counter=0; state→MUL; out_valid=0.
  - MUL: one shift-add step per cycle; after DSIZE steps, {out_hi,out} loads the unsigned product, zero=(full product==0), neg=out[DSIZE-1]; state→HOLD. Accept-to-out_valid latency is DSIZE+1 cycles.
  - HOLD: out_valid=1; outputs stable while out_ready=0.
    - out_ready=1 with no new accept → IDLE, out_valid=0.
    - out_ready=1 with a simultaneous accept → loads the new op (back-to-back, throughput 1 for non-MUL ops).
- In MUL state in_ready=0; in_valid is ignored and must be held by the producer.
- a, b, op may change freely when not accepted.
- out_hi is cleared to 0 by any non-MUL result.

Decomposition:
- Shared define file: DSIZE, OPW and all opcode constants (ALU_ADD…ALU_SLT), plus FSM state encodings.
- One sub-module, mul_seq: DSIZE-cycle unsigned shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done pulse, 2*DSIZE product.
  - Async reset on rst.

Test Plan:
- ADD a=16'h7FFF, b=16'h0001, out_ready=1 → 1 cycle after accept: out_valid=1, out=16'h8000, ovf=1, neg=1, carry=0, zero=0.
- SUB a=3, b=5 → out=16'hFFFE, carry=1, neg=1. BEQ a=b=16'h1234 → out=0, zero=1. BEQ a=1, b=2 → zero=0.
- MUL a=16'hFFFF, b=16'hFFFF → in_ready=0 for 16 cycles; out_valid at cycle 17; out=16'h0001, out_hi=16'hFFFE. A valid ADD presented meanwhile is accepted only once the MUL result is consumed.
- Backpressure: ADD result with out_ready=0 for 5 cycles → out and flags stable, in_ready=0. Then out_ready=1 together with in_valid XOR (a=16'hF0F0, b=16'h0FF0) → next cycle out=16'hFF00.
- Shifts/compares:
  - SRA a=16'h8000, b=16'h0013 (amount 3) → out=16'hF000.
  - SLT a=16'hFFFF, b=0 → 1.
  - COM a=16'hFFFF, b=0 → 0.
  - op 15 → out=0, flags 0.
- Reset asserted asynchronously in MUL cycle 7 → out_valid=0, out=0 immediately. After release, a new ADD a=2, b=3 → out=5 with latency 1.
